// File: rtl/reg_file_arb_pkg.sv
// Shared constants and types for the two-requester register-file front end.
// No logic; imported by the arbiter, register file and top.
package reg_file_arb_pkg;
    localparam int NUM_REQ          = 2;
    localparam int ADDR_WIDTH_DEF   = 7;
    localparam int DATA_WIDTH_DEF   = 8;

    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;
endpackage

// File: rtl/reg_file.sv
// Single-write-port, single-read-port register file; contents are not reset.
// Write lands at the clock edge; read is asynchronous.
module reg_file #(
    parameter int addr_width = 7,
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);
    logic [data_width-1:0] mem [0:(1<<addr_width)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer flips away from each winner.
// Zero-cycle grant; a requester not granted simply keeps requesting.
module rr_arb2
    import reg_file_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt
);
    req_id_t prio;

    always_comb begin
        gnt = '0;
        if (!rst) begin
            gnt[0] = req[0] & (~req[1] | (prio == req_id_t'(0)));
            gnt[1] = req[1] & (~req[0] | (prio == req_id_t'(1)));
        end
    end

    // The winner loses priority; an idle cycle leaves the pointer alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= '0;
        end else if (advance && (|gnt)) begin
            prio <= req_id_t'(gnt[0]);
        end
    end
endmodule

// File: rtl/reg_file_arbiter.sv
// Two-requester front end to the register file: independent round-robin write and read arbiters.
// Grants are same-cycle; read data returns registered one cycle later, forwarded from a colliding write.
module reg_file_arbiter
    import reg_file_arb_pkg::*;
#(
    parameter int addr_width = ADDR_WIDTH_DEF,
    parameter int data_width = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    wreq,
    input  logic [addr_width-1:0] waddr0,
    input  logic [addr_width-1:0] waddr1,
    input  logic [data_width-1:0] wdata0,
    input  logic [data_width-1:0] wdata1,
    output logic [NUM_REQ-1:0]    wgnt,
    input  logic [NUM_REQ-1:0]    rreq,
    input  logic [addr_width-1:0] raddr0,
    input  logic [addr_width-1:0] raddr1,
    output logic [NUM_REQ-1:0]    rgnt,
    output logic                  rvalid,
    output logic                  rid,
    output logic [data_width-1:0] rdata
);
    logic                  wen;
    logic [addr_width-1:0] wsel_addr;
    logic [data_width-1:0] wsel_data;
    logic [addr_width-1:0] rsel_addr;
    logic [data_width-1:0] rf_rdata;
    logic [data_width-1:0] fwd_data;

    // Nothing downstream can stall a granted transfer, so every grant advances.
    rr_arb2 u_warb (
        .clk     (clk),
        .rst     (rst),
        .req     (wreq),
        .advance (1'b1),
        .gnt     (wgnt)
    );

    rr_arb2 u_rarb (
        .clk     (clk),
        .rst     (rst),
        .req     (rreq),
        .advance (1'b1),
        .gnt     (rgnt)
    );

    assign wen       = |wgnt;
    assign wsel_addr = wgnt[1] ? waddr1 : waddr0;
    assign wsel_data = wgnt[1] ? wdata1 : wdata0;
    assign rsel_addr = rgnt[1] ? raddr1 : raddr0;

    reg_file #(
        .addr_width (addr_width),
        .data_width (data_width)
    ) u_rf (
        .clk   (clk),
        .we    (wen),
        .waddr (wsel_addr),
        .wdata (wsel_data),
        .raddr (rsel_addr),
        .rdata (rf_rdata)
    );

    // Array still holds the old word during the colliding cycle.
    assign fwd_data = (wen && (wsel_addr == rsel_addr)) ? wsel_data : rf_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            rid    <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= |rgnt;
            if (|rgnt) begin
                rid   <= rgnt[1];
                rdata <= fwd_data;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_arbiter.sv
// Scoreboard bench for reg_file_arbiter: expected grants from a reference pointer model,
// expected read returns queued at grant time and compared when rvalid appears.
module tb_reg_file_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] wreq, rreq;
    logic [6:0] waddr0, waddr1, raddr0, raddr1;
    logic [7:0] wdata0, wdata1;
    logic [1:0] wgnt, rgnt;
    logic       rvalid;
    logic       rid;
    logic [7:0] rdata;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] mem_m [0:127];
    logic       wprio_m, rprio_m;
    logic [8:0] sb [$];

    reg_file_arbiter #(.addr_width(7), .data_width(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .wreq   (wreq),
        .waddr0 (waddr0),
        .waddr1 (waddr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .wgnt   (wgnt),
        .rreq   (rreq),
        .raddr0 (raddr0),
        .raddr1 (raddr1),
        .rgnt   (rgnt),
        .rvalid (rvalid),
        .rid    (rid),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_gnt(input logic [1:0] req, input logic prio);
        if (req == 2'b11) return prio ? 2'b10 : 2'b01;
        return req;
    endfunction

    // Called at posedge+1: drive, check grants at negedge, update model, check output after edge.
    task automatic step(input logic [1:0] wr, input logic [6:0] wa0, input logic [7:0] wd0,
                        input logic [6:0] wa1, input logic [7:0] wd1,
                        input logic [1:0] rr, input logic [6:0] ra0, input logic [6:0] ra1);
        logic [1:0] ewg, erg;
        logic [6:0] wa, ra;
        logic [7:0] wd, d;
        wreq = wr; waddr0 = wa0; wdata0 = wd0; waddr1 = wa1; wdata1 = wd1;
        rreq = rr; raddr0 = ra0; raddr1 = ra1;
        #4;
        ewg = exp_gnt(wr, wprio_m);
        erg = exp_gnt(rr, rprio_m);
        check("wgnt", {30'd0, wgnt}, {30'd0, ewg});
        check("rgnt", {30'd0, rgnt}, {30'd0, erg});
        wa = ewg[1] ? wa1 : wa0;
        wd = ewg[1] ? wd1 : wd0;
        if (erg != 2'b00) begin
            ra = erg[1] ? ra1 : ra0;
            d  = mem_m[ra];
            if (ewg != 2'b00 && wa == ra) d = wd;
            sb.push_back({erg[1], d});
            rprio_m = erg[0];
        end
        if (ewg != 2'b00) begin
            mem_m[wa] = wd;
            wprio_m   = ewg[0];
        end
        @(posedge clk);
        #1;
        check("rvalid", {31'd0, rvalid}, {31'd0, sb.size() > 0});
        if (sb.size() > 0) begin
            logic [8:0] e;
            e = sb.pop_front();
            check("rid", {31'd0, rid}, {31'd0, e[8]});
            check("rdata", {24'd0, rdata}, {24'd0, e[7:0]});
        end
    endtask

    task automatic idle();
        step(2'b00, 7'd0, 8'd0, 7'd0, 8'd0, 2'b00, 7'd0, 7'd0);
    endtask

    initial begin
        wprio_m = 1'b0;
        rprio_m = 1'b0;
        rst  = 1'b1;
        wreq = 2'b11; rreq = 2'b11;
        waddr0 = 7'h00; waddr1 = 7'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        raddr0 = 7'h00; raddr1 = 7'h00;
        #12;
        check("rst_wgnt", {30'd0, wgnt}, 32'd0);
        check("rst_rgnt", {30'd0, rgnt}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rid", {31'd0, rid}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Preload: first grant after reset must go to requester 0.
        step(2'b11, 7'h7F, 8'hFF, 7'h00, 8'h01, 2'b00, 7'h00, 7'h00);
        step(2'b10, 7'h00, 8'h00, 7'h00, 8'h01, 2'b00, 7'h00, 7'h00);
        step(2'b01, 7'h05, 8'h00, 7'h00, 8'h00, 2'b00, 7'h00, 7'h00);

        // Single write by requester 1, read by requester 0.
        step(2'b10, 7'h00, 8'h00, 7'h10, 8'hA5, 2'b00, 7'h00, 7'h00);
        step(2'b00, 7'h00, 8'h00, 7'h00, 8'h00, 2'b01, 7'h10, 7'h00);
        idle();

        // Write contention: grants alternate 01,10,01,10.
        for (int i = 0; i < 4; i++)
            step(2'b11, 7'h01, 8'h11, 7'h02, 8'h22, 2'b00, 7'h00, 7'h00);
        step(2'b00, 7'h00, 8'h00, 7'h00, 8'h00, 2'b01, 7'h01, 7'h00);
        step(2'b00, 7'h00, 8'h00, 7'h00, 8'h00, 2'b10, 7'h00, 7'h02);
        idle();

        // Same-cycle write/read to one address forwards the write data.
        step(2'b01, 7'h05, 8'h3C, 7'h00, 8'h00, 2'b10, 7'h00, 7'h05);
        idle();

        // Back-to-back reads at the address extremes.
        for (int i = 0; i < 2; i++)
            step(2'b00, 7'h00, 8'h00, 7'h00, 8'h00, 2'b11, 7'h7F, 7'h00);
        idle();

        // Reset mid-read: flip rprio to 1, grant requester 1, reset before the edge.
        step(2'b00, 7'h00, 8'h00, 7'h00, 8'h00, 2'b01, 7'h10, 7'h00);
        rreq = 2'b10; raddr1 = 7'h02;
        #3;
        check("midrst_rgnt", {30'd0, rgnt}, 32'd2);
        rst = 1'b1;
        #1;
        check("midrst_rvalid_async", {31'd0, rvalid}, 32'd0);
        check("midrst_rgnt_forced", {30'd0, rgnt}, 32'd0);
        wprio_m = 1'b0;
        rprio_m = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_rvalid_edge", {31'd0, rvalid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_rvalid", {31'd0, rvalid}, 32'd0);

        // Pointer back at 0, contents intact.
        step(2'b00, 7'h00, 8'h00, 7'h00, 8'h00, 2'b11, 7'h10, 7'h02);
        step(2'b00, 7'h00, 8'h00, 7'h00, 8'h00, 2'b11, 7'h05, 7'h7F);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
